// File: rtl/shake_msg_feeder.sv
// shake_msg_feeder
// Upstream stage of the SHAKE256 core. It takes message bytes from a
// valid/ready stream, pulses the core's start input, and then feeds each byte
// to the core's 2-bit serial message interface, least-significant pair first.
// After the last chunk it emits a one-cycle end-of-message strobe. It then
// holds off the next message until the core reports done, so only one message
// is ever in flight.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      in_data / in_last are valid
//   in_data[7:0]  message byte
//   in_last       final byte of the message
//   in_ready      feeder accepts a byte on this edge when in_valid is high
//   core_done     done from the SHAKE256 core
//   core_start    one-cycle start pulse to the core
//   core_enable   core_serial is valid (core enable)
//   core_serial   2-bit message chunk (core serial_in)
//   core_end      one-cycle end of message (core serial_end_signal)
//   busy          high in every state except IDLE
//   byte_count    bytes accepted in the current message
//   overflow_err  sticky; message was truncated at MAX_BYTES
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for the first byte of a message
// START     | core_start pulse
// SHIFT     | four enabled 2-bit chunks of the current byte
// LOAD      | waiting for the next byte of an open message
// END       | core_end pulse
// WAIT_DONE | message delivered; waiting for core_done

module shake_msg_feeder #(
    parameter int MAX_BYTES = 135,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             core_done,
    output logic             core_start,
    output logic             core_enable,
    output logic [1:0]       core_serial,
    output logic             core_end,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count,
    output logic             overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_LOAD,
        S_END,
        S_WAIT_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    state_t           state;
    logic [7:0]       shift_reg;
    logic             last_r;
    logic [1:0]       chunk_idx;

    logic             accept;
    logic [CNT_W-1:0] accept_cnt;
    logic             at_limit;
    logic             close_msg;

    // accept_cnt is the byte number that this accept would make. Reaching
    // MAX_BYTES closes the message even if in_last is not set.
    always_comb begin
        accept     = in_valid & in_ready;
        accept_cnt = (state == S_IDLE) ? CNT_W'(1) : byte_count + CNT_W'(1);
        at_limit   = (accept_cnt == MAX_CNT);
        close_msg  = in_last | at_limit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            shift_reg    <= '0;
            last_r       <= 1'b0;
            chunk_idx    <= '0;
            in_ready     <= 1'b0;
            core_start   <= 1'b0;
            core_enable  <= 1'b0;
            core_serial  <= '0;
            core_end     <= 1'b0;
            busy         <= 1'b0;
            byte_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            // Strobes and the serial lane are low unless a state drives them.
            core_start  <= 1'b0;
            core_end    <= 1'b0;
            core_enable <= 1'b0;
            core_serial <= '0;

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        shift_reg    <= in_data;
                        last_r       <= close_msg;
                        byte_count   <= accept_cnt;
                        overflow_err <= at_limit & ~in_last;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        core_start   <= 1'b1;
                        state        <= S_START;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                S_START: begin
                    core_enable <= 1'b1;
                    core_serial <= shift_reg[1:0];
                    shift_reg   <= {2'b00, shift_reg[7:2]};
                    chunk_idx   <= '0;
                    state       <= S_SHIFT;
                end

                // chunk_idx is the chunk currently on core_serial.
                S_SHIFT: begin
                    if (chunk_idx == 2'd3) begin
                        if (last_r) begin
                            core_end <= 1'b1;
                            state    <= S_END;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end else begin
                        core_enable <= 1'b1;
                        core_serial <= shift_reg[1:0];
                        shift_reg   <= {2'b00, shift_reg[7:2]};
                        chunk_idx   <= chunk_idx + 2'd1;
                    end
                end

                // The first chunk of the new byte goes out directly from
                // in_data so it appears the cycle after the accept.
                S_LOAD: begin
                    if (accept) begin
                        core_enable <= 1'b1;
                        core_serial <= in_data[1:0];
                        shift_reg   <= {2'b00, in_data[7:2]};
                        chunk_idx   <= '0;
                        last_r      <= close_msg;
                        byte_count  <= accept_cnt;
                        if (at_limit && !in_last) begin
                            overflow_err <= 1'b1;
                        end
                        in_ready    <= 1'b0;
                        state       <= S_SHIFT;
                    end
                end

                S_END: begin
                    state <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (core_done) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shake_msg_feeder.sv
// tb_shake_msg_feeder
// Scoreboarded bench for shake_msg_feeder. The driver decides when each byte
// is accepted. From the byte value and the accept cycle it derives the core
// events the feeder must produce and the cycle of each one: start, four
// chunks, and end. A monitor compares every core event it sees against that
// queue.

module tb_shake_msg_feeder;

    localparam int MAX_BYTES = 135;
    localparam int CNT_W     = 8;

    localparam int K_START = 0;
    localparam int K_CHUNK = 1;
    localparam int K_END   = 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             core_done;
    logic             core_start;
    logic             core_enable;
    logic [1:0]       core_serial;
    logic             core_end;
    logic             busy;
    logic [CNT_W-1:0] byte_count;
    logic             overflow_err;

    shake_msg_feeder #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .core_done    (core_done),
        .core_start   (core_start),
        .core_enable  (core_enable),
        .core_serial  (core_serial),
        .core_end     (core_end),
        .busy         (busy),
        .byte_count   (byte_count),
        .overflow_err (overflow_err)
    );

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] msg_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state for the message being sent.
    bit msg_open  = 0;
    int msg_cnt   = 0;
    int exp_count = 0;
    int exp_ovf   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind %0d val %0d at cycle %0d, none expected",
                     kind, val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                failures++;
                $display("FAIL core_event: got kind %0d val %0d cycle %0d expected kind %0d val %0d cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every start, chunk and end the DUT presents is checked.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!core_enable && core_serial != 2'd0) begin
                failures++;
                $display("FAIL serial_idle: core_serial %0d while core_enable=0 at cycle %0d",
                         core_serial, cyc);
            end
            if (core_start)  pop_cmp(K_START, 0);
            if (core_enable) pop_cmp(K_CHUNK, int'(core_serial));
            if (core_end)    pop_cmp(K_END, 0);
        end
    end

    task automatic push_ev(input int kind, input int val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Call at a negedge; returns at the negedge after the accept.
    task automatic drive_byte(input logic [7:0] d, input bit last);
        int guard;
        int a;
        int base;
        bit first;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 2000 cycles");
            in_valid = 1'b0;
            return;
        end
        a = cyc + 1;
        @(posedge clk);
        first = !msg_open;
        if (first) begin
            msg_open = 1;
            msg_cnt  = 1;
            push_ev(K_START, 0, a);
            base = a + 1;
        end else begin
            msg_cnt++;
            base = a;
        end
        for (int k = 0; k < 4; k++) push_ev(K_CHUNK, (int'(d) >> (2 * k)) & 3, base + k);
        if (last || msg_cnt == MAX_BYTES) begin
            push_ev(K_END, 0, base + 4);
            msg_open  = 0;
            exp_count = msg_cnt;
            exp_ovf   = last ? 0 : 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // stall < 0 picks a random gap of 0..2 cycles between bytes.
    task automatic send_q(input int stall, input bit use_last);
        int n;
        n = msg_q.size();
        for (int i = 0; i < n; i++) begin
            drive_byte(msg_q[i], use_last && (i == n - 1));
            if (i < n - 1) begin
                int s;
                s = (stall < 0) ? $urandom_range(0, 2) : stall;
                repeat (s) @(negedge clk);
            end
        end
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL end_timeout: %0d core events still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_in_ready", in_ready, 0);
        chk("byte_count", byte_count, exp_count);
        chk("overflow_err", overflow_err, exp_ovf);
    endtask

    task automatic do_done();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk("busy_before_done", busy, 1);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("byte_count_hold", byte_count, exp_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_enable"}, core_enable, 0);
        chk({tag, "_core_serial"}, core_serial, 0);
        chk({tag, "_core_end"}, core_end, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
        chk({tag, "_overflow_err"}, overflow_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Single byte 0xB4: chunks 0,1,3,2.
        msg_q = '{8'hB4};
        send_q(0, 1);
        wait_end();
        do_done();

        // Three bytes back to back.
        msg_q = '{8'h01, 8'h80, 8'hFF};
        send_q(0, 1);
        wait_end();
        do_done();

        // core_done during SHIFT must be ignored.
        msg_q = '{8'($urandom), 8'($urandom)};
        fork
            send_q(0, 1);
            begin
                repeat (3) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        join
        wait_end();
        do_done();

        // Five-cycle stall in LOAD between bytes.
        msg_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send_q(5, 1);
        wait_end();
        do_done();

        // Overflow: 135 bytes without in_last, 136th held until done.
        msg_q.delete();
        for (int i = 0; i < MAX_BYTES; i++) msg_q.push_back(8'($urandom));
        send_q(0, 0);
        wait_end();
        held     = 8'($urandom);
        in_valid = 1'b1;
        in_data  = held;
        in_last  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("held_in_ready", in_ready, 0);
            chk("held_byte_count", byte_count, MAX_BYTES);
        end
        do_done();
        drive_byte(held, 1);
        wait_end();
        do_done();

        // Reset in the middle of SHIFT for byte 2.
        msg_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        drive_byte(msg_q[0], 0);
        drive_byte(msg_q[1], 0);
        #1;
        reset    = 1'b1;
        sb.delete();
        msg_open = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_in_ready", in_ready, 1);
        msg_q = '{8'($urandom)};
        send_q(0, 1);
        wait_end();
        do_done();

        // Random messages with random gaps.
        for (int m = 0; m < 6; m++) begin
            int len;
            len = $urandom_range(1, 8);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            send_q(-1, 1);
            wait_end();
            do_done();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shake_msg_feeder.md
Name: shake_msg_feeder

Overview:
Upstream stage of the SHAKE256 core. Accepts message bytes over a valid/ready stream and pulses the core's start input. Drives the core's 2-bit serial message interface (enable, serial_in, serial_end_signal). Holds off new messages until the core reports done, so exactly one message is in flight.

Parameters:
MAX_BYTES, 135, maximum message length in bytes; keeps one 1088-bit rate block with room for padding.
CNT_W, 8, width of the byte counter; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_data/in_last valid
in_data  in  8  message byte
in_last  in  1  marks the final byte of the message
in_ready  out  1  feeder can accept a byte this cycle
core_done  in  1  done from the SHAKE256 core
core_start  out  1  one-cycle start pulse to the core
core_enable  out  1  serial_in valid (drives the core's enable)
core_serial  out  2  2-bit message chunk (drives the core's serial_in)
core_end  out  1  one-cycle end-of-message (drives the core's serial_end_signal)
busy  out  1  high in every state except IDLE
byte_count  out  CNT_W  bytes accepted in the current message
overflow_err  out  1  sticky; message truncated at MAX_BYTES

Behaviour:
- The interface uses one clock. Reset is synchronous and active-high, and the clock and reset ports are named clk and reset.
- Reset values: state=IDLE, in_ready=0, core_start=0, core_enable=0, core_serial=0, core_end=0, busy=0, byte_count=0, overflow_err=0.
- Reset asserted mid-operation aborts immediately. All outputs take their reset values on the next edge, and no core_end is emitted.
- FSM states: IDLE, START, SHIFT, LOAD, END, WAIT_DONE.
- Accept rule: a byte is taken on an edge where in_valid & in_ready. On accept, the byte goes into shift_reg[7:0], in_last into last_r, and byte_count increments.
- IDLE: in_ready=1.
  - On accept: go to START. byte_count is set to 1 and overflow_err is cleared.
- START: core_start=1 for exactly one cycle, in_ready=0, then go to SHIFT.
- SHIFT: runs 4 cycles with core_enable=1 and in_ready=0.
  - Chunk order per byte is LSB pair first: [1:0], [3:2], [5:4], [7:6].
  - After the 4th chunk: go to END if last_r, otherwise go to LOAD.
- LOAD: in_ready=1, core_enable=0, core_serial=0.
  - On accept: go to SHIFT, so the first chunk appears the cycle after the accept edge.
- Overflow: accepting byte number MAX_BYTES with in_last=0 sets overflow_err=1 and forces last_r=1. The message is closed after that byte; later bytes wait in IDLE for the next message.
- END: core_end=1 for one cycle, core_enable=0, then go to WAIT_DONE.
- WAIT_DONE: in_ready=0 until core_done=1, then go to IDLE.
  - core_done arriving while in END is ignored.
  - core_done outside WAIT_DONE is ignored.
- Latency, first byte: accept at edge T gives core_start in cycle T+1 and chunks in cycles T+2..T+5. For a 1-byte message, core_end is in cycle T+6.
- Minimum message length is one byte; empty messages are not supported.
- core_serial=0 whenever core_enable=0.
- byte_count holds its value until the next message's first accept.

Test Plan:
- 1-byte message 0xB4 with in_last=1 -> core_start one cycle; core_serial=0,1,3,2 with enable for 4 cycles; core_end next cycle; busy stays high until core_done; byte_count=1.
- 3 bytes 0x01,0x80,0xFF sent back-to-back -> 12 enabled chunks: 1,0,0,0, 0,0,0,2, 3,3,3,3. in_ready is 0 during SHIFT. core_end after the last chunk. No enable gaps beyond the one-cycle LOAD per byte.
- 135 bytes with in_last=0 on all -> overflow_err=1 and core_end after byte 135. The 136th byte is not accepted until core_done returns the FSM to IDLE.
- core_done pulsed during SHIFT -> ignored, no return to IDLE. core_done in WAIT_DONE -> IDLE next cycle, in_ready=1.
- Reset asserted mid-SHIFT of byte 2 -> all outputs reach reset values after the next edge, no core_end. A new message afterwards starts with core_start and byte_count=1.
- in_valid stalled 5 cycles in LOAD -> core_enable=0 and core_serial=0 throughout; the stream resumes correctly on accept.
